// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared execute-stage definitions: datapath width, ALU opcodes and the
// HI/LO multiply sequencer state encoding.
package mul_hilo_ctrl_pkg;

    localparam int WIDTH = 32;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Opcode presented to the multiplier whenever it must hold its state.
    localparam logic [2:0] MUL_NOP = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        CAPTURE
    } state_t;

endpackage

// File: rtl/mul_hilo_ctrl.sv
// MULTU sequencer around the iterative shift-add multiplier, with the HI/LO
// result registers and the MFHI/MFLO/MTHI/MTLO access path.
module mul_hilo_ctrl #(
    parameter int         WIDTH      = mul_hilo_ctrl_pkg::WIDTH,
    parameter int         MUL_CYCLES = WIDTH,
    parameter logic [2:0] MUL_OP     = mul_hilo_ctrl_pkg::ALU_MUL
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   opA,
    input  logic [WIDTH-1:0]   opB,
    input  logic               mfhi,
    input  logic               mflo,
    input  logic               mthi,
    input  logic               mtlo,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [2*WIDTH-1:0] mul_product,
    output logic               mul_rst,
    output logic [2:0]         mul_signal,
    output logic [WIDTH-1:0]   mul_dataA,
    output logic [WIDTH-1:0]   mul_dataB,
    output logic [WIDTH-1:0]   rd_data,
    output logic               busy,
    output logic               stall
);
    import mul_hilo_ctrl_pkg::*;

    localparam int CW = $clog2(MUL_CYCLES + 1);

    state_t           state_reg;
    state_t           state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] opa_reg;
    logic [WIDTH-1:0] opb_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            opa_reg   <= '0;
            opb_reg   <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    // An issuing MULTU takes precedence; a coincident move-to is dropped.
                    if (start) begin
                        opa_reg <= opA;
                        opb_reg <= opB;
                    end else begin
                        if (mthi) hi_reg <= wr_data;
                        if (mtlo) lo_reg <= wr_data;
                    end
                end
                LOAD:    cnt_reg <= '0;
                RUN:     cnt_reg <= cnt_reg + CW'(1);
                CAPTURE: begin
                    hi_reg <= mul_product[2*WIDTH-1:WIDTH];
                    lo_reg <= mul_product[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        mul_rst    = rst;
        mul_signal = MUL_NOP;
        case (state_reg)
            IDLE:    if (start) state_next = LOAD;
            LOAD: begin
                mul_rst    = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                mul_signal = MUL_OP;
                if (cnt_reg == CW'(MUL_CYCLES - 1)) state_next = CAPTURE;
            end
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign mul_dataA = opa_reg;
    assign mul_dataB = opb_reg;
    assign busy      = (state_reg != IDLE);
    assign stall     = busy & (start | mfhi | mflo | mthi | mtlo);

    // Reads see the register contents before any same-cycle move-to lands.
    always_comb begin
        rd_data = '0;
        if (!stall) begin
            if (mfhi)      rd_data = hi_reg;
            else if (mflo) rd_data = lo_reg;
        end
    end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Bench for mul_hilo_ctrl paired with a behavioural shift-add multiplier;
// stimulus queues expectations, a monitor process compares and counts them.
module tb_mul_hilo_ctrl;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   opA = '0;
    logic [W-1:0]   opB = '0;
    logic           mfhi = 1'b0;
    logic           mflo = 1'b0;
    logic           mthi = 1'b0;
    logic           mtlo = 1'b0;
    logic [W-1:0]   wr_data = '0;
    logic [2*W-1:0] mul_product;
    logic           mul_rst;
    logic [2:0]     mul_signal;
    logic [W-1:0]   mul_dataA;
    logic [W-1:0]   mul_dataB;
    logic [W-1:0]   rd_data;
    logic           busy;
    logic           stall;

    mul_hilo_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .opA        (opA),
        .opB        (opB),
        .mfhi       (mfhi),
        .mflo       (mflo),
        .mthi       (mthi),
        .mtlo       (mtlo),
        .wr_data    (wr_data),
        .mul_product(mul_product),
        .mul_rst    (mul_rst),
        .mul_signal (mul_signal),
        .mul_dataA  (mul_dataA),
        .mul_dataB  (mul_dataB),
        .rd_data    (rd_data),
        .busy       (busy),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    // Execute-stage multiplier: one shift-add step per clock while opcode is MUL.
    logic [2*W-1:0] acc;
    logic [W:0]     step_sum;
    assign step_sum    = acc[0] ? ({1'b0, acc[2*W-1:W]} + {1'b0, mul_dataA})
                                : {1'b0, acc[2*W-1:W]};
    assign mul_product = acc;

    always @(posedge clk) begin
        if (mul_rst)                  acc <= {{W{1'b0}}, mul_dataB};
        else if (mul_signal == 3'b100) acc <= {step_sum, acc[W-1:1]};
    end

    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] exp;
    } chk_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } rd_t;

    chk_t chk_q[$];
    rd_t  rd_q[$];
    int   passed = 0;
    int   total  = 0;
    bit   done   = 1'b0;

    task automatic push_chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input bit is_hi, input logic [31:0] exp, input string name);
        rd_t r;
        sync();
        mfhi   = is_hi;
        mflo   = ~is_hi;
        r.name = name;
        r.exp  = exp;
        rd_q.push_back(r);
        sync();
        mfhi = 1'b0;
        mflo = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        sync();
        start = 1'b1;
        opA   = a;
        opB   = b;
        sync();
        start = 1'b0;
    endtask

    task automatic wait_idle(output int nbusy, output int nmul);
        bit seen_idle;
        seen_idle = 1'b0;
        nbusy = 0;
        nmul  = 0;
        for (int i = 0; i < 200 && !seen_idle; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            else      seen_idle = 1'b1;
            if (mul_signal == 3'b100) nmul++;
        end
        if (!seen_idle) push_chk("idle_timeout", 64'd0, 64'd1);
    endtask

    // Monitor: a read is presented whenever mfhi/mflo is asserted without stall.
    initial begin
        rd_t  r;
        chk_t c;
        do begin
            @(negedge clk);
            if ((mfhi || mflo) && !stall) begin
                total++;
                if (rd_q.size() == 0) begin
                    $display("FAIL unexpected_read: rd_data=%h with nothing expected", rd_data);
                end else begin
                    r = rd_q.pop_front();
                    if (rd_data === r.exp) passed++;
                    else $display("FAIL %s: rd_data=%h expected %h", r.name, rd_data, r.exp);
                end
            end
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                total++;
                if (c.act === c.exp) passed++;
                else $display("FAIL %s: got %0h expected %0h", c.name, c.act, c.exp);
            end
        end while (!done);
        while (rd_q.size() > 0) begin
            r = rd_q.pop_front();
            total++;
            $display("FAIL %s: read never presented, expected %h", r.name, r.exp);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int nm;

        // Reset behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        push_chk("rst_mul_rst", 64'(mul_rst), 64'd1);
        push_chk("rst_busy", 64'(busy), 64'd0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        push_chk("post_rst_mul_rst", 64'(mul_rst), 64'd0);
        do_read(1'b1, 32'd0, "rst_hi");
        do_read(1'b0, 32'd0, "rst_lo");

        // 7 x 6: timing of busy and the mul opcode
        issue(32'd7, 32'd6);
        push_chk("load_mul_rst", 64'(mul_rst), 64'd1);
        push_chk("dataA_7", 64'(mul_dataA), 64'd7);
        push_chk("dataB_6", 64'(mul_dataB), 64'd6);
        wait_idle(nb, nm);
        push_chk("busy_cycles", 64'(nb), 64'd34);
        push_chk("mul_op_cycles", 64'(nm), 64'd32);
        do_read(1'b0, 32'd42, "lo_7x6");
        do_read(1'b1, 32'd0, "hi_7x6");

        // Full-scale operands
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(nb, nm);
        do_read(1'b1, 32'hFFFF_FFFE, "hi_max");
        do_read(1'b0, 32'h0000_0001, "lo_max");

        // Move-to in IDLE, and read-before-write in the same cycle
        sync();
        mthi = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        push_chk("mthi_stall", 64'(stall), 64'd0);
        sync();
        mthi = 1'b0;
        mtlo = 1'b1;
        wr_data = 32'h1234_5678;
        @(negedge clk);
        push_chk("mtlo_stall", 64'(stall), 64'd0);
        sync();
        mtlo = 1'b0;
        do_read(1'b1, 32'hDEAD_BEEF, "mfhi_moved");
        do_read(1'b0, 32'h1234_5678, "mflo_moved");
        sync();
        mthi = 1'b1;
        mfhi = 1'b1;
        wr_data = 32'h1111_2222;
        rd_q.push_back('{name: "rd_old_same_cycle", exp: 32'hDEAD_BEEF});
        sync();
        mthi = 1'b0;
        mfhi = 1'b0;
        do_read(1'b1, 32'h1111_2222, "rd_after_write");

        // 3 x 5 with mflo held during the multiply
        issue(32'd3, 32'd5);
        repeat (9) sync();
        mflo = 1'b1;
        rd_q.push_back('{name: "lo_3x5_after_stall", exp: 32'd15});
        begin
            bit idle_seen;
            idle_seen = 1'b0;
            for (int i = 0; i < 60 && !idle_seen; i++) begin
                @(negedge clk);
                if (busy) begin
                    push_chk("mflo_stall_busy", 64'(stall), 64'd1);
                    push_chk("mflo_rd_zero", 64'(rd_data), 64'd0);
                end else begin
                    push_chk("mflo_stall_idle", 64'(stall), 64'd0);
                    idle_seen = 1'b1;
                end
            end
            if (!idle_seen) push_chk("mflo_idle_timeout", 64'd0, 64'd1);
        end
        sync();
        mflo = 1'b0;

        // 3 x 5 with a second start (2 x 2) held while busy
        issue(32'd3, 32'd5);
        repeat (4) sync();
        start = 1'b1;
        opA = 32'd2;
        opB = 32'd2;
        begin
            bit idle_seen;
            idle_seen = 1'b0;
            for (int i = 0; i < 60 && !idle_seen; i++) begin
                @(negedge clk);
                if (busy) begin
                    push_chk("start_stall", 64'(stall), 64'd1);
                    push_chk("start_ignored_dataA", 64'(mul_dataA), 64'd3);
                end else begin
                    idle_seen = 1'b1;
                end
            end
            if (!idle_seen) push_chk("start_idle_timeout", 64'd0, 64'd1);
        end
        sync();
        start = 1'b0;
        push_chk("second_start_busy", 64'(busy), 64'd1);
        wait_idle(nb, nm);
        do_read(1'b0, 32'd4, "lo_2x2");

        // 9 x 9 aborted by reset mid-run
        issue(32'd9, 32'd9);
        repeat (19) sync();
        rst = 1'b1;
        @(negedge clk);
        push_chk("abort_mul_rst", 64'(mul_rst), 64'd1);
        sync();
        rst = 1'b0;
        @(negedge clk);
        push_chk("abort_busy", 64'(busy), 64'd0);
        push_chk("abort_mul_signal", 64'(mul_signal), 64'd0);
        do_read(1'b1, 32'd0, "abort_hi");
        do_read(1'b0, 32'd0, "abort_lo");
        issue(32'd9, 32'd9);
        wait_idle(nb, nm);
        do_read(1'b0, 32'd81, "lo_9x9");
        do_read(1'b1, 32'd0, "hi_9x9");

        repeat (3) sync();
        done = 1'b1;
    end

endmodule

// File: doc/mul_hilo_ctrl.md
Name: mul_hilo_ctrl

Overview:
Sequencing and result stage wrapped around the 32-iteration shift-add multiplier in the execute path. It accepts a MULTU request from the pipeline and latches the operands. It pulses the multiplier's load reset, holds the multiplier's mul opcode for exactly MUL_CYCLES clocks, then captures the 64-bit product into HI/LO. It serves MFHI/MFLO/MTHI/MTLO and stalls the pipeline while a multiply is in flight.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH each, product is 2*WIDTH.
MUL_CYCLES, 32, number of clocks the multiplier must see its mul opcode; equals WIDTH.
MUL_OP, 3'b100, opcode driven on the multiplier signal input while running.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  reset; synchronous, active-high.
start  in  1  MULTU issue (one-cycle pulse from decode).
opA  in  WIDTH  multiplicand, sampled when start is accepted.
opB  in  WIDTH  multiplier operand, sampled when start is accepted.
mfhi  in  1  read HI request.
mflo  in  1  read LO request.
mthi  in  1  write HI request.
mtlo  in  1  write LO request.
wr_data  in  WIDTH  data for mthi/mtlo.
mul_product  in  2*WIDTH  product from the multiplier.
mul_rst  out  1  load/clear pulse to the multiplier.
mul_signal  out  3  opcode to the multiplier.
mul_dataA  out  WIDTH  latched opA to the multiplier.
mul_dataB  out  WIDTH  latched opB to the multiplier.
rd_data  out  WIDTH  HI or LO read data.
busy  out  1  multiply in flight.
stall  out  1  pipeline hold request.

Behaviour:
- States: IDLE, LOAD, RUN, CAPTURE. Register cnt is $clog2(MUL_CYCLES+1) bits wide.
- Reset (rst=1 at an edge):
  - state goes to IDLE; hi, lo, cnt, opA_q and opB_q go to 0.
  - mul_rst=1 combinationally for any cycle rst is high, so the multiplier clears as well.
  - Reset mid-operation aborts the multiply. HI/LO are zeroed, not left at a partial value.
- IDLE:
  - start=1: latch opA/opB and go to LOAD.
  - Otherwise mthi writes hi<=wr_data and mtlo writes lo<=wr_data; both may be asserted together.
  - Priority: start over mthi/mtlo. A move-to is dropped if asserted with start.
- LOAD (1 cycle): mul_rst=1, mul_signal=3'b000. Next state RUN, cnt<=0.
- RUN:
  - mul_signal=MUL_OP, cnt increments each cycle.
  - After the cycle where cnt==MUL_CYCLES-1, go to CAPTURE. Exactly MUL_CYCLES RUN cycles.
- CAPTURE (1 cycle): hi<=mul_product[2W-1:W], lo<=mul_product[W-1:0], next state IDLE.
- Outside RUN: mul_signal=3'b000. mul_dataA/mul_dataB always equal opA_q/opB_q and are stable for the whole operation.
- Latency: start sampled at edge E0 puts new HI/LO visible after edge E0+MUL_CYCLES+2 (34 for the defaults).
- busy = (state != IDLE).
- stall = busy & (start|mfhi|mflo|mthi|mtlo).
  - start while busy is ignored, and stall holds it until IDLE.
  - Move-to and move-from while busy are ignored and stalled.
- rd_data (combinational):
  - When not stalled: hi if mfhi, else lo if mflo, else 0.
  - mfhi wins over mflo.
  - A read in the same cycle as mthi/mtlo returns the old value; the write lands at the edge.
- Arithmetic: unsigned only. The product is taken verbatim from the multiplier; no sign handling in this block.

Decomposition:
- Shared package: ALU opcode constants (MUL_OP=3'b100 alongside the existing ALU codes), the state enum, and WIDTH.
- No sub-module required. The instantiating execute stage wires mul_* to the existing multiplier. The bench instantiates both blocks together.

Test Plan:
- Reset, then start with opA=7, opB=6. Expect busy for 34 cycles and mul_signal=3'b100 for exactly 32 cycles. Then mflo -> rd_data=42 and mfhi -> 0.
- opA=opB=0xFFFFFFFF. Expect HI=0xFFFFFFFE and LO=0x00000001.
- In IDLE: mthi wr_data=0xDEADBEEF, then mtlo 0x12345678. Expect mfhi=0xDEADBEEF, mflo=0x12345678, and stall=0 throughout.
- Start 3×5, then assert mflo on cycle 10 and hold it. Expect stall=1 and rd_data=0 until IDLE. The next cycle returns 15 with stall=0.
- Start 3×5, then a second start 2×2 on cycle 5 held high. Expect stall until IDLE; the second multiply then runs and LO ends at 4.
- Start 9×9, then rst on cycle 20. Expect IDLE next edge, HI=LO=0, busy=0, mul_rst=1 during rst. A following 9×9 yields LO=81.
